// File: rtl/uart_loader_pkg.sv
// loader_pkg: state encoding and frame constants shared by the uart_loader slice.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } loader_state_t;

  // Length prefix is a little-endian 16-bit word count.
  localparam int LEN_BYTES = 2;

  function automatic int bytes_per_word(input int xlen);
    return xlen / 8;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: byte stream from the UART receiver and the instruction-memory
// write port. The master modport is the loader side, slave is the UART/imem side.
interface uart_loader_if #(
  parameter int XLEN = 32,
  parameter int AW   = 8
);
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            imem_we;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_wdata;

  modport master (
    input  rx_valid,
    input  rx_data,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_valid,
    output rx_data,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/uart_loader_word_assembler.sv
// word_assembler: packs bytes little-endian into XLEN-bit words. word_valid is
// combinational and flags the byte that completes a word; word is that word.
module word_assembler
  import loader_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  localparam int BPW = bytes_per_word(XLEN);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] shift_q, shift_d;
  logic [XLEN-1:0] packed_word;
  logic            last_byte;

  // New bytes enter at the top so the first byte ends up in the LSBs.
  if (XLEN == 8) begin : g_single
    assign packed_word = byte_data;
  end else begin : g_multi
    assign packed_word = {byte_data, shift_q[XLEN-1:8]};
  end

  assign last_byte  = (idx_q == IW'(BPW - 1));
  assign word_valid = byte_valid && !start && last_byte;
  assign word       = packed_word;

  // Byte index and shift register update; start clears for a fresh image.
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (start) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      idx_d   = last_byte ? '0 : idx_q + IW'(1);
      shift_d = packed_word;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// uart_loader: framed, length-prefixed program download from the UART into
// instruction memory. Frame: LEN_LO, LEN_HI, N words LSB first, optional CSUM.
// Build option LOADER_CHECKSUM_EN adds the trailing checksum byte and checker;
// without it the frame ends after the data and checksum_err is tied low.
//
// state | meaning
// IDLE  | core runs normally, waiting for flash
// LEN0  | waiting for word-count low byte
// LEN1  | waiting for word-count high byte
// DATA  | receiving image bytes, writing words
// CSUM  | waiting for checksum byte
// DONE  | image complete, hold until flash drops
module uart_loader
  import loader_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flash,
  uart_loader_if.master bus,
  output logic          core_hold,
  output logic          load_done,
  output logic          overflow,
  output logic [15:0]   word_count,
  output logic          checksum_err
);

  loader_state_t state_q, state_d;

  logic [8*LEN_BYTES-1:0] len_q, len_d;
  logic [15:0]            word_count_q, word_count_d;
  logic [AW-1:0]          imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]        imem_wdata_q, imem_wdata_d;
  logic                   imem_we_q, imem_we_d;
  logic                   overflow_q, overflow_d;
  logic                   load_done_q, load_done_d;

  logic                   asm_start;
  logic                   asm_valid;
  logic                   word_valid;
  logic [XLEN-1:0]        asm_word;
  logic                   in_range;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
  logic                   checksum_err_q, checksum_err_d;
`endif

  // A data byte is consumed only while flash is still high; abort wins.
  assign asm_start = (state_q == IDLE) && flash;
  assign asm_valid = (state_q == DATA) && flash && bus.rx_valid;
  assign in_range  = ({16'd0, word_count_q} < 32'(DEPTH));

  word_assembler #(.XLEN(XLEN)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .start      (asm_start),
    .byte_valid (asm_valid),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (asm_word)
  );

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    imem_we_d    = 1'b0;
    overflow_d   = overflow_q;
    load_done_d  = load_done_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d         = csum_q;
    checksum_err_d = checksum_err_q;
`endif

    // Address advances the cycle after each write pulse.
    if (imem_we_q) imem_addr_d = imem_addr_q + AW'(1);

    unique case (state_q)
      IDLE: begin
        if (flash) begin
          state_d      = LEN0;
          len_d        = '0;
          word_count_d = '0;
          imem_addr_d  = '0;
          overflow_d   = 1'b0;
          load_done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_d         = '0;
          checksum_err_d = 1'b0;
`endif
        end
      end
      LEN0: begin
        if (!flash) begin
          state_d = IDLE;
        end else if (bus.rx_valid) begin
          len_d[7:0] = bus.rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (!flash) begin
          state_d = IDLE;
        end else if (bus.rx_valid) begin
          len_d[15:8] = bus.rx_data;
          if ({bus.rx_data, len_q[7:0]} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d     = DONE;
            load_done_d = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (!flash) begin
          state_d = IDLE;
        end else if (asm_valid) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + bus.rx_data;
`endif
          if (word_valid) begin
            word_count_d = word_count_q + 16'd1;
            // Words past the end of memory still count toward N.
            if (in_range) begin
              imem_we_d    = 1'b1;
              imem_wdata_d = asm_word;
            end else begin
              overflow_d = 1'b1;
            end
            if (word_count_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d     = DONE;
              load_done_d = 1'b1;
`endif
            end
          end
        end
      end
      CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (!flash) begin
          state_d = IDLE;
        end else if (bus.rx_valid) begin
          checksum_err_d = (bus.rx_data != csum_q);
          load_done_d    = 1'b1;
          state_d        = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (!flash) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_we_q    <= 1'b0;
      overflow_q   <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      imem_we_q    <= imem_we_d;
      overflow_q   <= overflow_d;
      load_done_q  <= load_done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Checksum accumulator and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q         <= '0;
      checksum_err_q <= 1'b0;
    end else begin
      csum_q         <= csum_d;
      checksum_err_q <= checksum_err_d;
    end
  end

  assign checksum_err = checksum_err_q;
`else
  assign checksum_err = 1'b0;
`endif

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_hold      = (state_q != IDLE);
  assign load_done      = load_done_q;
  assign overflow       = overflow_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: dut_a is XLEN=32/DEPTH=4, dut_b is XLEN=16/DEPTH=256.
module tb_uart_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flash_a = 1'b0;
  logic flash_b = 1'b0;

  always #5 clk = ~clk;

  uart_loader_if #(.XLEN(32), .AW(2)) if_a ();
  uart_loader_if #(.XLEN(16), .AW(8)) if_b ();

  logic        hold_a, done_a, ovf_a, cerr_a;
  logic [15:0] wc_a;
  logic        hold_b, done_b, ovf_b, cerr_b;
  logic [15:0] wc_b;

  uart_loader #(.XLEN(32), .DEPTH(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .flash        (flash_a),
    .bus          (if_a.master),
    .core_hold    (hold_a),
    .load_done    (done_a),
    .overflow     (ovf_a),
    .word_count   (wc_a),
    .checksum_err (cerr_a)
  );

  uart_loader #(.XLEN(16), .DEPTH(256)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .flash        (flash_b),
    .bus          (if_b.master),
    .core_hold    (hold_b),
    .load_done    (done_b),
    .overflow     (ovf_b),
    .word_count   (wc_b),
    .checksum_err (cerr_b)
  );

  typedef struct {
    int          addr;
    logic [63:0] data;
    int          when;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [7:0]  tx_bytes[$];
  logic [63:0] tx_words[$];
  int n_chk   = 0;
  int n_fail  = 0;
  int neg_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write, in the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (if_a.imem_we === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a unexpected write addr", 64'(if_a.imem_addr), 64'hFFFF);
      end else begin
        e = q_a.pop_front();
        check("a write addr", 64'(if_a.imem_addr), 64'(e.addr));
        check("a write data", 64'(if_a.imem_wdata), e.data);
        check("a write cycle", 64'(neg_cnt), 64'(e.when));
      end
    end
    if (if_b.imem_we === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b unexpected write addr", 64'(if_b.imem_addr), 64'hFFFF);
      end else begin
        e = q_b.pop_front();
        check("b write addr", 64'(if_b.imem_addr), 64'(e.addr));
        check("b write data", 64'(if_b.imem_wdata), e.data);
        check("b write cycle", 64'(neg_cnt), 64'(e.when));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      if_a.rx_valid = 1'b1;
      if_a.rx_data  = b;
    end else begin
      if_b.rx_valid = 1'b1;
      if_b.rx_data  = b;
    end
    sync();
    if_a.rx_valid = 1'b0;
    if_b.rx_valid = 1'b0;
  endtask

  // Sends a frame built from tx_words/tx_bytes; nsend<0 sends all data bytes.
  task automatic send_frame(input int sel, input int bpw, input int depth,
                            input int nsend, input logic [7:0] csum);
    int   n;
    int   nb;
    int   lim;
    exp_t e;
    n   = tx_words.size();
    nb  = n * bpw;
    lim = (nsend < 0) ? nb : nsend;
    sync();
    if (sel == 0) flash_a = 1'b1;
    else          flash_b = 1'b1;
    sync();
    drive_byte(sel, 8'(n));
    drive_byte(sel, 8'(n >> 8));
    for (int i = 0; i < lim; i++) begin
      drive_byte(sel, tx_bytes[i]);
      if ((i % bpw) == bpw - 1 && (i / bpw) < depth) begin
        e.addr = i / bpw;
        e.data = tx_words[i / bpw];
        e.when = neg_cnt + 1;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (lim == nb) drive_byte(sel, csum);
`else
    if (csum == 8'h00 && lim < 0) drive_byte(sel, csum);
`endif
  endtask

  task automatic stat_a(input string tag, input logic hold, input logic ld,
                        input logic ov, input int wc, input logic ce);
    check({tag, " core_hold"}, 64'(hold_a), 64'(hold));
    check({tag, " load_done"}, 64'(done_a), 64'(ld));
    check({tag, " overflow"}, 64'(ovf_a), 64'(ov));
    check({tag, " word_count"}, 64'(wc_a), 64'(wc));
    check({tag, " checksum_err"}, 64'(cerr_a), 64'(ce));
  endtask

  task automatic drop_flash_a();
    sync();
    flash_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic exp_bad;

  initial begin
    if_a.rx_valid = 1'b0;
    if_a.rx_data  = 8'h00;
    if_b.rx_valid = 1'b0;
    if_b.rx_data  = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    exp_bad = 1'b1;
`else
    exp_bad = 1'b0;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    stat_a("reset a", 0, 0, 0, 0, 0);
    check("reset a imem_we", 64'(if_a.imem_we), 64'h0);
    check("reset a imem_addr", 64'(if_a.imem_addr), 64'h0);
    check("reset a imem_wdata", 64'(if_a.imem_wdata), 64'h0);
    check("reset b core_hold", 64'(hold_b), 64'h0);
    check("reset b imem_we", 64'(if_b.imem_we), 64'h0);
    sync();
    rst = 1'b0;

    // Basic two-word image.
    tx_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    tx_words = '{64'h0000_0013, 64'h0010_0093};
    send_frame(0, 4, 4, -1, 8'hB6);
    @(negedge clk);
    stat_a("basic", 1, 1, 0, 2, 0);
    // Bytes in DONE are ignored.
    sync();
    for (int i = 0; i < 4; i++) drive_byte(0, 8'hFF);
    @(negedge clk);
    check("done ignores word_count", 64'(wc_a), 64'd2);
    drop_flash_a();
    stat_a("basic release", 0, 1, 0, 2, 0);

    // Overflow: 6 words into a 4-deep memory.
    tx_bytes.delete();
    tx_words = '{64'h0403_0201, 64'h0807_0605, 64'h0C0B_0A09,
                 64'h100F_0E0D, 64'h1413_1211, 64'h1817_1615};
    for (int i = 0; i < 24; i++) tx_bytes.push_back(8'(i + 1));
    send_frame(0, 4, 4, -1, 8'h2C);
    @(negedge clk);
    stat_a("overflow", 1, 1, 1, 6, 0);
    drop_flash_a();

    // Checksum good then bad.
    tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    tx_words = '{64'h0403_0201};
    send_frame(0, 4, 4, -1, 8'h0A);
    @(negedge clk);
    stat_a("csum good", 1, 1, 0, 1, 0);
    drop_flash_a();
    send_frame(0, 4, 4, -1, 8'h0B);
    @(negedge clk);
    stat_a("csum bad", 1, 1, 0, 1, exp_bad);
    drop_flash_a();

    // Abort after 5 data bytes.
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    tx_words = '{64'h4433_2211, 64'h8877_6655};
    send_frame(0, 4, 4, 5, 8'h00);
    drop_flash_a();
    stat_a("abort", 0, 0, 0, 1, 0);
    sync();
    for (int i = 0; i < 3; i++) drive_byte(0, 8'hEE);
    @(negedge clk);
    check("abort idle word_count", 64'(wc_a), 64'd1);

    // flash falls together with the byte completing the only word.
    tx_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tx_words = '{64'hDDCC_BBAA};
    send_frame(0, 4, 4, 3, 8'h00);
    flash_a       = 1'b0;
    if_a.rx_valid = 1'b1;
    if_a.rx_data  = 8'hDD;
    sync();
    if_a.rx_valid = 1'b0;
    @(negedge clk);
    stat_a("collision", 0, 0, 0, 0, 0);

    // Synchronous reset in the middle of DATA.
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    tx_words = '{64'h4433_2211, 64'h8877_6655};
    send_frame(0, 4, 4, 6, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stat_a("mid rst", 0, 0, 0, 0, 0);
    check("mid rst imem_we", 64'(if_a.imem_we), 64'h0);
    check("mid rst imem_wdata", 64'(if_a.imem_wdata), 64'h0);
    sync();
    rst     = 1'b0;
    flash_a = 1'b0;
    for (int i = 0; i < 4; i++) drive_byte(0, 8'h77);
    @(negedge clk);
    stat_a("post rst", 0, 0, 0, 0, 0);

    // XLEN=16, three words back to back.
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    tx_words = '{64'h2211, 64'h4433, 64'h6655};
    send_frame(1, 2, 256, -1, 8'h65);
    @(negedge clk);
    check("x16 load_done", 64'(done_b), 64'h1);
    check("x16 word_count", 64'(wc_b), 64'd3);
    check("x16 overflow", 64'(ovf_b), 64'h0);
    check("x16 checksum_err", 64'(cerr_b), 64'h0);
    sync();
    flash_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("x16 core_hold released", 64'(hold_b), 64'h0);

    check("a pending writes", 64'(q_a.size()), 64'd0);
    check("b pending writes", 64'(q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
